mole_game_ctrl: RTL and testbench



---
 rtl/mole_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-Mole game logic: spawns, ages and scores moles in 9 holes and runs the game timer.
// Drives the registered map/score buses consumed by the display stage.
module mole_game_ctrl #(
    parameter int TICK_DIV    = 10_000_000,
    parameter int SPAWN_TICKS = 8,
    parameter int LIFE_TICKS  = 12,
    parameter int GAME_TICKS  = 300,
    parameter int MAX_MOLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] hit,
    output logic [8:0] map,
    output logic [3:0] score,
    output logic       playing,
    output logic       game_over
);

    localparam int              TW         = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [7:0]      SPAWN_LAST = 8'(SPAWN_TICKS - 1);
    localparam logic [7:0]      LIFE_INIT  = 8'(LIFE_TICKS);
    localparam logic [15:0]     GAME_END   = 16'(GAME_TICKS);
    localparam logic [3:0]      MOLE_CAP   = 4'(MAX_MOLES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt, tick_cnt_next;
    logic [7:0]    spawn_cnt, spawn_cnt_next;
    logic [15:0]   game_cnt, game_cnt_next;
    logic [7:0]    life [9];
    logic [7:0]    life_next [9];
    logic [8:0]    map_next;
    logic [3:0]    score_next;
    logic [15:0]   lfsr;

    logic          tick;
    logic [8:0]    hit_eff;
    logic [8:0]    expire;
    logic          spawn_go;
    logic [3:0]    cand;
    logic [4:0]    idx5;
    logic [3:0]    idx;
    logic          found;
    logic [8:0]    spawn_oh;
    logic [4:0]    score_sum;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // All occupancy decisions look at map as it stood at the start of the cycle,
    // so holes being hit or expiring this cycle still count as taken.
    always_comb begin
        tick     = (tick_cnt == TICK_LAST);
        hit_eff  = hit & map;
        expire   = '0;
        for (int i = 0; i < 9; i++)
            expire[i] = tick && map[i] && (life[i] == 8'd1) && !hit_eff[i];
        spawn_go = tick && (spawn_cnt == SPAWN_LAST) && (popcount9(map) < MOLE_CAP);
    end

    always_comb begin
        cand     = (lfsr[3:0] >= 4'd9) ? (lfsr[3:0] - 4'd9) : lfsr[3:0];
        spawn_oh = '0;
        found    = 1'b0;
        idx5     = '0;
        idx      = '0;
        for (int j = 0; j < 9; j++) begin
            idx5 = {1'b0, cand} + 5'(j);
            if (idx5 >= 5'd9) idx5 = idx5 - 5'd9;
            idx = idx5[3:0];
            if (!found && !map[idx]) begin
                spawn_oh[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        tick_cnt_next  = tick_cnt;
        spawn_cnt_next = spawn_cnt;
        game_cnt_next  = game_cnt;
        map_next       = map;
        score_next     = score;
        life_next      = life;
        score_sum      = '0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_next     = PLAY;
                    tick_cnt_next  = '0;
                    spawn_cnt_next = '0;
                    game_cnt_next  = '0;
                    map_next       = '0;
                    score_next     = '0;
                    for (int i = 0; i < 9; i++) life_next[i] = '0;
                end
            end
            PLAY: begin
                tick_cnt_next = tick ? '0 : tick_cnt + TW'(1);
                score_sum     = {1'b0, score} + {1'b0, popcount9(hit_eff)};
                score_next    = score_sum[4] ? 4'd15 : score_sum[3:0];
                for (int i = 0; i < 9; i++) begin
                    if (hit_eff[i])
                        life_next[i] = '0;
                    else if (tick && map[i])
                        life_next[i] = life[i] - 8'd1;
                end
                if (tick) begin
                    game_cnt_next  = game_cnt + 16'd1;
                    spawn_cnt_next = (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + 8'd1;
                end
                map_next = map & ~hit_eff & ~expire;
                if (spawn_go) begin
                    map_next = map_next | spawn_oh;
                    for (int i = 0; i < 9; i++)
                        if (spawn_oh[i]) life_next[i] = LIFE_INIT;
                end
                // Hits this cycle are already folded into score_next before the end check.
                if ((tick && (game_cnt_next == GAME_END)) || (score_next == 4'd15)) begin
                    state_next = OVER;
                    map_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            game_cnt  <= '0;
            map       <= '0;
            score     <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            lfsr      <= 16'hACE1;
            for (int i = 0; i < 9; i++) life[i] <= '0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            spawn_cnt <= spawn_cnt_next;
            game_cnt  <= game_cnt_next;
            map       <= map_next;
            score     <= score_next;
            playing   <= (state_next == PLAY);
            game_over <= (state_next == OVER);
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            life      <= life_next;
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed game scenarios on two instances (short and long game)
// compared against a cycle-stepped reference game model.
module tb_mole_game_ctrl;

    localparam int TD = 4;
    localparam int ST = 2;
    localparam int LT = 3;
    localparam int GA = 20;
    localparam int GB = 100;
    localparam int MM = 3;

    logic       clk;
    logic [1:0] rst_v;
    logic [1:0] start_v;
    logic [8:0] hit_v [2];
    logic [8:0] map_a, map_b;
    logic [3:0] score_a, score_b;
    logic       playing_a, playing_b, over_a, over_b;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 0;
    int t = 0;

    mole_game_ctrl #(.TICK_DIV(TD), .SPAWN_TICKS(ST), .LIFE_TICKS(LT), .GAME_TICKS(GA),
                     .MAX_MOLES(MM)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .hit(hit_v[0]),
        .map(map_a), .score(score_a), .playing(playing_a), .game_over(over_a));

    mole_game_ctrl #(.TICK_DIV(TD), .SPAWN_TICKS(ST), .LIFE_TICKS(LT), .GAME_TICKS(GB),
                     .MAX_MOLES(MM)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .hit(hit_v[1]),
        .map(map_b), .score(score_b), .playing(playing_b), .game_over(over_b));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // reference model: state 0=IDLE 1=PLAY 2=OVER
    int          m_st [2], m_tick [2], m_spn [2], m_game [2], m_score [2], m_new [2];
    int          m_life [2][9];
    logic [8:0]  m_map [2];
    logic [15:0] m_lfsr [2];
    int          n_st [2], n_tick [2], n_spn [2], n_game [2], n_score [2], n_new [2];
    int          n_life [2][9];
    logic [8:0]  n_map [2];
    logic [15:0] n_lfsr [2];

    always_comb begin
        int up, cand, p, gt;
        logic wrap, placed;
        for (int k = 0; k < 2; k++) begin
            up = 0; cand = 0; p = 0; wrap = 1'b0; placed = 1'b0;
            gt = (k == 0) ? GA : GB;
            n_st[k] = m_st[k]; n_tick[k] = m_tick[k]; n_spn[k] = m_spn[k];
            n_game[k] = m_game[k]; n_score[k] = m_score[k]; n_map[k] = m_map[k];
            n_new[k] = -1;
            for (int i = 0; i < 9; i++) n_life[k][i] = m_life[k][i];
            n_lfsr[k] = {m_lfsr[k][14:0], m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
            if (!rst_v[k]) begin
                n_st[k] = 0; n_tick[k] = 0; n_spn[k] = 0; n_game[k] = 0; n_score[k] = 0;
                n_map[k] = '0; n_lfsr[k] = 16'hACE1;
                for (int i = 0; i < 9; i++) n_life[k][i] = 0;
            end else if (m_st[k] != 1) begin
                if (start_v[k]) begin
                    n_st[k] = 1; n_tick[k] = 0; n_spn[k] = 0; n_game[k] = 0; n_score[k] = 0;
                    n_map[k] = '0;
                    for (int i = 0; i < 9; i++) n_life[k][i] = 0;
                end
            end else begin
                wrap = (m_tick[k] == TD - 1);
                n_tick[k] = wrap ? 0 : m_tick[k] + 1;
                for (int i = 0; i < 9; i++) if (m_map[k][i]) up++;
                for (int i = 0; i < 9; i++) begin
                    if (hit_v[k][i] && m_map[k][i]) begin
                        n_map[k][i] = 1'b0; n_life[k][i] = 0;
                        if (n_score[k] < 15) n_score[k]++;
                    end else if (wrap && m_map[k][i]) begin
                        if (m_life[k][i] == 1) begin
                            n_map[k][i] = 1'b0; n_life[k][i] = 0;
                        end else n_life[k][i] = m_life[k][i] - 1;
                    end
                end
                if (wrap) begin
                    n_game[k] = m_game[k] + 1;
                    if (m_spn[k] == ST - 1) begin
                        n_spn[k] = 0;
                        if (up < MM) begin
                            cand = int'(m_lfsr[k][3:0]);
                            if (cand >= 9) cand -= 9;
                            for (int j = 0; j < 9; j++) begin
                                p = (cand + j) % 9;
                                if (!placed && !m_map[k][p]) begin
                                    n_map[k][p] = 1'b1; n_life[k][p] = LT; n_new[k] = p; placed = 1'b1;
                                end
                            end
                        end
                    end else n_spn[k] = m_spn[k] + 1;
                end
                if ((wrap && n_game[k] == gt) || n_score[k] == 15) begin
                    n_st[k] = 2; n_map[k] = '0;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_st <= n_st; m_tick <= n_tick; m_spn <= n_spn; m_game <= n_game;
        m_score <= n_score; m_new <= n_new; m_life <= n_life; m_map <= n_map; m_lfsr <= n_lfsr;
    end

    // scoreboard helpers
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pop9(input logic [8:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) if (v[i]) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_map_a", 16'(map_a), 16'(m_map[0]));
            check("cyc_score_a", 16'(score_a), 16'(m_score[0]));
            check("cyc_playing_a", 16'(playing_a), 16'(m_st[0] == 1));
            check("cyc_over_a", 16'(over_a), 16'(m_st[0] == 2));
            check("cyc_map_b", 16'(map_b), 16'(m_map[1]));
            check("cyc_score_b", 16'(score_b), 16'(m_score[1]));
            check("cyc_playing_b", 16'(playing_b), 16'(m_st[1] == 1));
            check("cyc_over_b", 16'(over_b), 16'(m_st[1] == 2));
        end
    end

    // driver tasks (called at a negedge)
    task automatic start_game(input int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        t = 0;
    endtask

    task automatic adv_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        int maxpc, hole, guard;
        rst_v = 2'b00; start_v = 2'b00; hit_v[0] = '0; hit_v[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_map", 16'(map_a), 16'h0);
        check("rst_score", 16'(score_a), 16'h0);
        check("rst_playing", 16'(playing_a), 16'h0);
        check("rst_over", 16'(over_a), 16'h0);
        check("rst_map_b", 16'(map_b), 16'h0);
        rst_v = 2'b11;
        chk_on = 1'b1;

        // hits in IDLE do nothing
        hit_v[0] = 9'h1FF;
        repeat (2) @(negedge clk);
        hit_v[0] = '0;
        check("idle_hit_score", 16'(score_a), 16'h0);
        check("idle_hit_playing", 16'(playing_a), 16'h0);

        // game A: no hits, full length
        start_game(0);
        check("start_playing", 16'(playing_a), 16'h1);
        check("start_map", 16'(map_a), 16'h0);
        check("start_score", 16'(score_a), 16'h0);
        maxpc = 0;
        hole = 0;
        for (int n = 1; n <= 80; n++) begin
            adv_to(n);
            if (pop9(map_a) > maxpc) maxpc = pop9(map_a);
            if (n == 7) check("pre_spawn_map", 16'(map_a), 16'h0);
            if (n == 8) begin
                check("first_spawn_count", 16'(pop9(map_a)), 16'd1);
                check("first_spawn_hole", 16'(map_a), 16'(9'(1) << m_new[0]));
                hole = m_new[0];
            end
            if (n == 19) check("life_last_tick", 16'(map_a[hole]), 16'h1);
            if (n == 20) check("life_expired", 16'(map_a[hole]), 16'h0);
            if (n == 79) check("before_end_playing", 16'(playing_a), 16'h1);
        end
        check("max_moles", 16'(maxpc <= MM), 16'h1);
        check("end_over", 16'(over_a), 16'h1);
        check("end_playing", 16'(playing_a), 16'h0);
        check("end_map", 16'(map_a), 16'h0);
        check("end_score", 16'(score_a), 16'h0);

        // hits in OVER do nothing
        hit_v[0] = 9'h1FF;
        repeat (3) @(negedge clk);
        hit_v[0] = '0;
        check("over_hit_score", 16'(score_a), 16'h0);
        check("over_hit_map", 16'(map_a), 16'h0);
        check("over_hold", 16'(over_a), 16'h1);

        // game B: hits
        start_game(0);
        check("restart_playing", 16'(playing_a), 16'h1);
        adv_to(16);
        check("two_up", 16'(pop9(map_a)), 16'd2);
        hit_v[0] = m_map[0];
        adv_to(17);
        hit_v[0] = '0;
        check("dbl_hit_map", 16'(map_a), 16'h0);
        check("dbl_hit_score", 16'(score_a), 16'd2);
        adv_to(24);
        check("one_up", 16'(pop9(map_a)), 16'd1);
        hit_v[0] = m_map[0];
        adv_to(25);
        hit_v[0] = '0;
        check("single_hit_map", 16'(map_a), 16'h0);
        check("single_hit_score", 16'(score_a), 16'd3);
        hit_v[0] = ~m_map[0];
        adv_to(26);
        hit_v[0] = '0;
        check("empty_hit_score", 16'(score_a), 16'd3);
        check("empty_hit_map", 16'(map_a), 16'h0);
        start_v[0] = 1'b1;
        adv_to(28);
        start_v[0] = 1'b0;
        check("start_in_play", 16'(playing_a), 16'h1);
        check("start_in_play_score", 16'(score_a), 16'd3);
        adv_to(32);
        hole = m_new[0];
        check("spawn_t8", 16'(pop9(map_a)), 16'd1);
        adv_to(43);
        check("expiring_up", 16'(map_a[hole]), 16'h1);
        hit_v[0] = 9'(1) << hole;
        adv_to(44);
        hit_v[0] = '0;
        check("expire_hit_score", 16'(score_a), 16'd4);
        check("expire_hit_map", 16'(map_a[hole]), 16'h0);
        adv_to(79);
        check("b_before_end", 16'(playing_a), 16'h1);
        adv_to(80);
        check("b_end_over", 16'(over_a), 16'h1);
        check("b_end_score", 16'(score_a), 16'd4);

        // game C: restart from OVER, then reset mid-game
        start_game(0);
        check("c_score", 16'(score_a), 16'h0);
        check("c_over", 16'(over_a), 16'h0);
        adv_to(16);
        check("c_two_up", 16'(pop9(map_a)), 16'd2);
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("midrst_map", 16'(map_a), 16'h0);
        check("midrst_score", 16'(score_a), 16'h0);
        check("midrst_playing", 16'(playing_a), 16'h0);
        check("midrst_over", 16'(over_a), 16'h0);
        rst_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 16'(playing_a), 16'h0);

        // long game on instance B: reach 14, then double hit saturates and ends
        start_game(1);
        guard = 0;
        while (m_score[1] < 14 && guard < 600) begin
            hit_v[1] = m_map[1] & (~m_map[1] + 9'd1);
            @(negedge clk);
            guard++;
        end
        hit_v[1] = '0;
        check("reach14", 16'(guard < 600), 16'h1);
        check("score14", 16'(score_b), 16'd14);
        while (pop9(m_map[1]) < 2 && guard < 1200) begin
            @(negedge clk);
            guard++;
        end
        check("two_up_b", 16'(pop9(map_b)), 16'd2);
        check("still_playing_b", 16'(playing_b), 16'h1);
        hit_v[1] = m_map[1];
        @(negedge clk);
        hit_v[1] = '0;
        check("sat_score", 16'(score_b), 16'd15);
        check("sat_over", 16'(over_b), 16'h1);
        check("sat_playing", 16'(playing_b), 16'h0);
        check("sat_map", 16'(map_b), 16'h0);
        repeat (2) @(negedge clk);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
